cla_pipe_adder: RTL
===================

// Module: cla_pipe_adder
// PURPOSE
//  Pipelined WIDTH-bit adder built from 4-bit carry-lookahead slices.
//  Each slice produces a 4-bit sum plus group propagate and generate; slices
//  are chained through the group carries.
//  The operation is split over two registered stages: low half, then high half.
//  Valid/ready handshake on both sides. Sits between operand source and result consumer.
// PARAMETERS
//  WIDTH  16  operand/sum width; must be a multiple of 8 (two halves of whole 4-bit slices)
// PORTS
//  CLK        in   1      rising-edge clock
//  RST        in   1      asynchronous, active-high reset
//  IN_VALID   in   1      operand word valid
//  IN_READY   out  1      block accepts operands this cycle
//  A          in   WIDTH  operand A (unsigned or two's complement)
//  B          in   WIDTH  operand B
//  C0         in   1      carry-in
//  OUT_VALID  out  1      result valid
//  OUT_READY  in   1      consumer accepts result this cycle
//  S          out  WIDTH  sum A+B+C0, modulo 2^WIDTH
//  CO         out  1      carry-out of MSB (unsigned overflow)
//  OVF        out  1      signed overflow: A[MSB]==B[MSB] && S[MSB]!=A[MSB]
// BEHAVIOUR
//  - Reset (async assert, sync release):
//    s1_valid=0, OUT_VALID=0, S=0, CO=0, OVF=0, all internal data regs=0.
//  - Transfer rules: input accepted when IN_VALID&&IN_READY.
//    Output consumed when OUT_VALID&&OUT_READY.
//  - Stage 1 (on accept):
//    lower WIDTH/2 bits = A+B+C0 via the chained slices.
//    Registers: low sum, carry into bit WIDTH/2, A/B upper halves, A[MSB], B[MSB];
//    sets s1_valid.
//  - Stage 2: upper half = A_hi+B_hi+mid carry via slices.
//    Registers S={hi,lo}, CO, OVF; sets OUT_VALID.
//  - Latency: 2 cycles from accept to OUT_VALID when not stalled.
//  - Throughput: 1 result/cycle while OUT_READY=1.
//  - Flow control:
//    s2_adv   = s1_valid && (!OUT_VALID || OUT_READY)
//    IN_READY = !s1_valid || s2_adv
//    IN_READY is combinational from OUT_READY; no combinational path IN_VALID->OUT_VALID.
//  - Stall: OUT_VALID&&!OUT_READY holds S/CO/OVF stable.
//    Stage 1 holds if occupied.
//    At most 2 words in flight; IN_READY=0 when both stages are full.
//  - Simultaneous events:
//    consume + advance + accept in one cycle is legal, with no bubble and no loss.
//    OUT_VALID drops only when consumed with no stage-1 word advancing.
//  - Wrap-around: all-ones + 1 -> S=0, CO=1.
//    No saturation; carries beyond the MSB are discarded.
//  - Reset mid-operation: in-flight words discarded; first post-reset accept
//    behaves as from idle.
//  - Inputs are sampled only on accept. A/B/C0 may change freely when not accepted.
//  - Ordering: results leave in acceptance order; no reorder, no drop, no duplication.
// TESTING
//  1 Reset: RST=1 mid-stream -> OUT_VALID=0, S=0, CO=0, OVF=0, IN_READY=1 after release.
//  2 Basic: A=16'h1234, B=16'h0FF0, C0=1, OUT_READY=1 -> 2 cycles later S=16'h2225, CO=0, OVF=0.
//  3 Carry across halves: A=16'h00FF, B=16'h0001, C0=0 -> S=16'h0100.
//    Then A=16'hFFFF, B=16'h0000, C0=1 -> S=16'h0000, CO=1.
//  4 Signed overflow: A=16'h7FFF, B=16'h0001 -> S=16'h8000, OVF=1, CO=0.
//    A=16'h8000, B=16'h8000 -> S=0, OVF=1, CO=1.
//  5 Backpressure: OUT_READY=0 while streaming 3 words ->
//    IN_READY=0 after 2 accepts, S stable.
//    Release -> 3 results in order, no loss.
//  6 Full rate: 100 random back-to-back words, OUT_READY=1 ->
//    one result per cycle, each matches reference A+B+C0 incl. CO/OVF.

Source files
------------

// File: rtl/cla_pipe_adder.sv
// cla_pipe_adder: two-stage pipelined WIDTH-bit adder built from chained
// 4-bit carry-lookahead slices. Stage 1 adds the low half and captures the
// mid carry plus the upper operand halves; stage 2 adds the upper half and
// registers the full result. Valid/ready handshake on both sides.
//
// WIDTH must be a multiple of 8 so each half is made of whole 4-bit slices.
//
// Ports:
//   CLK        rising-edge clock
//   RST        asynchronous active-high reset
//   IN_VALID   operand word valid
//   IN_READY   block accepts operands this cycle (combinational from OUT_READY)
//   A, B       operands (unsigned or two's complement)
//   C0         carry-in
//   OUT_VALID  result valid
//   OUT_READY  consumer accepts result this cycle
//   S          sum A+B+C0 modulo 2^WIDTH
//   CO         carry-out of the MSB
//   OVF        signed overflow
module cla_pipe_adder #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             C0,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic [WIDTH-1:0] S,
  output logic             CO,
  output logic             OVF
);

  localparam int unsigned HALF = WIDTH / 2;
  localparam int unsigned NSL  = HALF / 4;

  // One 4-bit lookahead slice: returns {group_generate, group_propagate, sum[3:0]}.
  function automatic logic [5:0] cla4(input logic [3:0] a, input logic [3:0] b,
                                      input logic cin);
    logic [3:0] p;
    logic [3:0] g;
    logic [3:0] c;
    logic       gp;
    logic       gg;
    p    = a ^ b;
    g    = a & b;
    c[0] = cin;
    c[1] = g[0] | (p[0] & cin);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
    gp   = &p;
    gg   = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
    return {gg, gp, p ^ c};
  endfunction

  // Half-width adder: slices chained through their group carries; returns {carry_out, sum}.
  function automatic logic [HALF:0] add_half(input logic [HALF-1:0] a,
                                             input logic [HALF-1:0] b,
                                             input logic cin);
    logic [HALF-1:0] sum;
    logic            carry;
    logic [5:0]      r;
    sum   = '0;
    carry = cin;
    for (int unsigned i = 0; i < NSL; i++) begin
      r             = cla4(a[4*i +: 4], b[4*i +: 4], carry);
      sum[4*i +: 4] = r[3:0];
      carry         = r[5] | (r[4] & carry);
    end
    return {carry, sum};
  endfunction

  logic            s1_valid;
  logic [HALF-1:0] s1_lo;
  logic            s1_c;
  logic [HALF-1:0] s1_a_hi;
  logic [HALF-1:0] s1_b_hi;
  logic            s1_a_msb;
  logic            s1_b_msb;

  logic            accept;
  logic            s2_adv;
  logic [HALF:0]   lo_res;
  logic [HALF:0]   hi_res;

  // Handshake: stage 1 may advance when the output register is empty or draining.
  assign s2_adv   = s1_valid && (!OUT_VALID || OUT_READY);
  assign IN_READY = !s1_valid || s2_adv;
  assign accept   = IN_VALID && IN_READY;

  always_comb lo_res = add_half(A[HALF-1:0], B[HALF-1:0], C0);
  always_comb hi_res = add_half(s1_a_hi, s1_b_hi, s1_c);

  // Stage 1: low-half sum, mid carry and upper operand halves.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      s1_valid <= 1'b0;
      s1_lo    <= '0;
      s1_c     <= 1'b0;
      s1_a_hi  <= '0;
      s1_b_hi  <= '0;
      s1_a_msb <= 1'b0;
      s1_b_msb <= 1'b0;
    end else if (accept) begin
      s1_valid <= 1'b1;
      s1_lo    <= lo_res[HALF-1:0];
      s1_c     <= lo_res[HALF];
      s1_a_hi  <= A[WIDTH-1:HALF];
      s1_b_hi  <= B[WIDTH-1:HALF];
      s1_a_msb <= A[WIDTH-1];
      s1_b_msb <= B[WIDTH-1];
    end else if (s2_adv) begin
      s1_valid <= 1'b0;
    end
  end

  // Stage 2: upper-half sum and result flags; holds while the consumer stalls.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      OUT_VALID <= 1'b0;
      S         <= '0;
      CO        <= 1'b0;
      OVF       <= 1'b0;
    end else if (s2_adv) begin
      OUT_VALID <= 1'b1;
      S         <= {hi_res[HALF-1:0], s1_lo};
      CO        <= hi_res[HALF];
      OVF       <= (s1_a_msb == s1_b_msb) && (hi_res[HALF-1] != s1_a_msb);
    end else if (OUT_READY) begin
      OUT_VALID <= 1'b0;
    end
  end

endmodule
